// File: rtl/xor_pkg.sv
// Shared definitions for the XOR frame-parity block.
//   state_t   : frame FSM state (IDLE = no beat held, ACCUM = partial frame held)
//   EVEN/ODD  : parity-mode values for the ODD_PARITY parameter
//   clog2     : ceiling log2, used to size the beat counter
package xor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int EVEN = 0;
  localparam int ODD  = 1;

  // Never returns less than 1 so a counter is always at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/xor_frame_parity_if.sv
// Stream bus for xor_frame_parity: input beat channel and result channel.
//   in_valid/in_ready/in_data/in_last : beat handshake, in_last marks frame end
//   out_valid/out_ready               : result handshake
//   out_col/out_par/out_beats/out_ovf : column checksum, parity, beat count, overflow
// master = the side feeding beats and consuming results; slave = the block.
interface xor_frame_parity_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_col;
  logic              out_par;
  logic [CNT_W-1:0]  out_beats;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_col, out_par, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_col, out_par, out_beats, out_ovf
  );
endinterface

// File: rtl/xor_reduce.sv
// Combinational XOR reduction of a W-bit word to a single bit.
//   din  : word to reduce
//   dout : XOR of all bits of din
module xor_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic         dout
);

  // Balanced tree: each level folds pairs of nodes from the level below.
  localparam int N = (W < 1) ? 1 : W;
  logic [2*N-2:0] node;

  always_comb begin
    node = '0;
    for (int i = 0; i < N; i++) node[N-1+i] = din[i];
    for (int i = N-2; i >= 0; i--) node[i] = node[2*i+1] ^ node[2*i+2];
  end

  assign dout = node[0];

endmodule

// File: rtl/xor_frame_parity.sv
// Per-frame XOR column checksum and parity over a valid/ready beat stream.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, discards any partial frame and result
//   flush : synchronous abandon of the partial frame; pending result is kept
//   bus   : slave side of xor_frame_parity_if (beat input, one-entry result output)
// A result (checksum, parity, beat count, overflow) appears the cycle after
// the last beat of a frame is accepted and holds until consumed.
module xor_frame_parity
  import xor_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int MAX_BEATS  = 16,
  parameter  int ODD_PARITY = EVEN,
  localparam int CNT_W      = clog2(MAX_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  xor_frame_parity_if.slave    bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic             PAR_INV = (ODD_PARITY != EVEN);

  // Saturating increment: the counter sticks at MAX_CNT instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == MAX_CNT) ? MAX_CNT : c + 1'b1;
  endfunction

  state_t            state_p0;
  logic [DATA_W-1:0] acc_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              ovf_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] col_p1;
  logic              par_p1;
  logic [CNT_W-1:0]  beats_p1;
  logic              ovf_p1;

  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] next_col;
  logic [CNT_W-1:0]  next_cnt;
  logic              next_ovf;
  logic              col_red;

  // A stalled result blocks every beat, last or not, so the accumulator
  // never runs ahead of a result it could not hand off.
  assign in_ready = ~flush & (~vld_p1 | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // ---- stage p0: accumulate the incoming beat ----
  // In IDLE the accumulator is already clear; selecting on state keeps the
  // first beat independent of any stale accumulator contents.
  always_comb begin
    if (state_p0 == IDLE) begin
      next_col = bus.in_data;
      next_cnt = sat_inc('0);
      next_ovf = 1'b0;
    end else begin
      next_col = acc_p0 ^ bus.in_data;
      next_cnt = sat_inc(cnt_p0);
      next_ovf = ovf_p0 | (cnt_p0 == MAX_CNT);
    end
  end

  xor_reduce #(.W(DATA_W)) u_reduce (
    .din  (next_col),
    .dout (col_red)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
    end else if (flush) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
    end else if (accept) begin
      if (bus.in_last) begin
        state_p0 <= IDLE;
        acc_p0   <= '0;
        cnt_p0   <= '0;
        ovf_p0   <= 1'b0;
      end else begin
        state_p0 <= ACCUM;
        acc_p0   <= next_col;
        cnt_p0   <= next_cnt;
        ovf_p0   <= next_ovf;
      end
    end
  end

  // ---- stage p1: one-entry result register ----
  // Loading a new result takes precedence over the consume, so a result can
  // be replaced in the same cycle it is taken with no bubble on out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      col_p1   <= '0;
      par_p1   <= 1'b0;
      beats_p1 <= '0;
      ovf_p1   <= 1'b0;
    end else if (accept && bus.in_last) begin
      vld_p1   <= 1'b1;
      col_p1   <= next_col;
      par_p1   <= col_red ^ PAR_INV;
      beats_p1 <= next_cnt;
      ovf_p1   <= next_ovf;
    end else if (bus.out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_col   = col_p1;
  assign bus.out_par   = par_p1;
  assign bus.out_beats = beats_p1;
  assign bus.out_ovf   = ovf_p1;

endmodule

// File: tb/tb_xor_frame_parity.sv
module tb_xor_frame_parity;
  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush2;

  always #5 clk = ~clk;

  xor_frame_parity_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus  ();
  xor_frame_parity_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus2 ();

  xor_frame_parity #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .ODD_PARITY(0)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  xor_frame_parity #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .ODD_PARITY(1)) u_odd (
    .clk   (clk),
    .rst   (rst),
    .flush (flush2),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [7:0] col;
    logic       par;
    logic [2:0] beats;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic [7:0] m_acc = 8'h00;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_acc = 8'h00;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Reference behaviour for one accepted beat; a last beat pushes a result.
  task automatic model_accept(input logic [7:0] d, input logic last);
    logic [7:0] col_n;
    int         cnt_n;
    logic       ovf_n;
    exp_t       e;
    col_n = m_acc ^ d;
    cnt_n = (m_cnt == MAX_BEATS) ? MAX_BEATS : m_cnt + 1;
    ovf_n = m_ovf | (m_cnt == MAX_BEATS);
    if (last) begin
      e.col   = col_n;
      e.par   = ^col_n;
      e.beats = 3'(cnt_n);
      e.ovf   = ovf_n;
      sb_q.push_back(e);
      model_clear();
    end else begin
      m_acc = col_n;
      m_cnt = cnt_n;
      m_ovf = ovf_n;
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic beat(input logic [7:0] d, input logic last);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(d, last);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          chk("beat_accept_timeout", 32'(bus.in_ready), 1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Scoreboard: every consumed result is checked against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 32'(bus.out_valid), 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_col",   32'(bus.out_col),   32'(e.col));
        chk("sb_par",   32'(bus.out_par),   32'(e.par));
        chk("sb_beats", 32'(bus.out_beats), 32'(e.beats));
        chk("sb_ovf",   32'(bus.out_ovf),   32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_col;
    logic       hold_par;
    logic [2:0] hold_beats;
    logic       hold_ovf;

    rst = 1'b1;
    flush = 1'b0;
    flush2 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0;
    bus2.in_data = 8'h00;
    bus2.in_last = 1'b0;
    bus2.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_col",   32'(bus.out_col),   0);
    chk("rst_par",   32'(bus.out_par),   0);
    chk("rst_beats", 32'(bus.out_beats), 0);
    chk("rst_ovf",   32'(bus.out_ovf),   0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single-beat frame
    beat(8'hA5, 1'b1);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_col",   32'(bus.out_col),   'hA5);
    chk("t1_par",   32'(bus.out_par),   0);
    chk("t1_beats", 32'(bus.out_beats), 1);
    chk("t1_ovf",   32'(bus.out_ovf),   0);
    @(posedge clk); #1;
    chk("t1_drain_valid", 32'(bus.out_valid), 0);

    // Three-beat frame followed back-to-back by a one-beat frame
    beat(8'h0F, 1'b0);
    beat(8'hF0, 1'b0);
    beat(8'h01, 1'b1);
    chk("t2_col",   32'(bus.out_col),   'hFE);
    chk("t2_par",   32'(bus.out_par),   1);
    chk("t2_beats", 32'(bus.out_beats), 3);
    beat(8'h3C, 1'b1);
    chk("t2b_valid", 32'(bus.out_valid), 1);
    chk("t2b_col",   32'(bus.out_col),   'h3C);
    chk("t2b_par",   32'(bus.out_par),   0);
    @(posedge clk); #1;

    // Backpressure: result held, beats blocked, then consume+reload together
    bus.out_ready = 1'b0;
    beat(8'h11, 1'b1);
    chk("t3_valid", 32'(bus.out_valid), 1);
    hold_col   = bus.out_col;
    hold_par   = bus.out_par;
    hold_beats = bus.out_beats;
    hold_ovf   = bus.out_ovf;
    chk("t3_col", 32'(hold_col), 'h11);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_in_ready", 32'(bus.in_ready),  0);
      chk("t3_hold_valid",    32'(bus.out_valid), 1);
      chk("t3_hold_col",      32'(bus.out_col),   32'(hold_col));
      chk("t3_hold_par",      32'(bus.out_par),   32'(hold_par));
      chk("t3_hold_beats",    32'(bus.out_beats), 32'(hold_beats));
      chk("t3_hold_ovf",      32'(bus.out_ovf),   32'(hold_ovf));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    beat(8'h80, 1'b1);
    chk("t3_reload_valid", 32'(bus.out_valid), 1);
    chk("t3_reload_col",   32'(bus.out_col),   'h80);
    chk("t3_reload_par",   32'(bus.out_par),   1);
    @(posedge clk); #1;

    // Overflow: six beats with MAX_BEATS = 4
    for (int i = 0; i < 5; i++) beat(8'h01, 1'b0);
    beat(8'h01, 1'b1);
    chk("t4_col",   32'(bus.out_col),   'h00);
    chk("t4_par",   32'(bus.out_par),   0);
    chk("t4_beats", 32'(bus.out_beats), 4);
    chk("t4_ovf",   32'(bus.out_ovf),   1);
    @(posedge clk); #1;

    // Flush discards the partial frame and blocks the beat presented with it
    beat(8'hFF, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    @(negedge clk);
    chk("t5_flush_in_ready", 32'(bus.in_ready), 0);
    model_clear();
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    beat(8'h03, 1'b1);
    chk("t5_col",   32'(bus.out_col),   'h03);
    chk("t5_beats", 32'(bus.out_beats), 1);
    chk("t5_ovf",   32'(bus.out_ovf),   0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a frame
    beat(8'h55, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_col",   32'(bus.out_col),   0);
    chk("t6_rst_beats", 32'(bus.out_beats), 0);
    model_clear();
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    beat(8'h0A, 1'b1);
    chk("t6_col",   32'(bus.out_col),   'h0A);
    chk("t6_beats", 32'(bus.out_beats), 1);
    @(posedge clk); #1;

    // Odd-parity instance
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'h00;
    bus2.in_last  = 1'b1;
    @(negedge clk);
    chk("t7_in_ready", 32'(bus2.in_ready), 1);
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("t7_odd_valid0", 32'(bus2.out_valid), 1);
    chk("t7_odd_par0",   32'(bus2.out_par),   1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'h01;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("t7_odd_col1", 32'(bus2.out_col), 'h01);
    chk("t7_odd_par1", 32'(bus2.out_par), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xor_frame_parity.md
Name: xor_frame_parity

Overview:
- Parametrised successor to the single-bit XOR gate: streams multi-beat frames of DATA_W-bit words and accumulates a bitwise XOR column checksum per frame.
- Reduces that checksum to a single even/odd parity bit and reports the frame beat count.
- Sits between a data source and a link/check stage that needs per-frame XOR parity.
- Valid/ready handshake on both sides, one-entry registered output.

Parameters:
- DATA_W, 8, width of each input word and of the column checksum.
- MAX_BEATS, 16, largest countable frame length; longer frames saturate and flag overflow.
- ODD_PARITY, 0, 0 = even parity (out_par = XOR of all bits), 1 = odd parity (inverted).
- CNT_W, clog2(MAX_BEATS+1), derived width of the beat counter; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abandon of partial frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_W  input word
- in_last  in  1  marks final beat of frame
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_col  out  DATA_W  bitwise XOR of all words in frame
- out_par  out  1  reduction XOR of out_col, XOR ODD_PARITY
- out_beats  out  CNT_W  beats in frame, saturating at MAX_BEATS
- out_ovf  out  1  frame exceeded MAX_BEATS beats

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, cnt=0, ovf_acc=0; out_valid=0, out_col=0, out_par=0, out_beats=0, out_ovf=0. Applies mid-frame; the partial frame is discarded.
- in_ready = ~flush & (~out_valid | out_ready), combinational. The rule is the same for last and non-last beats.
- Beat accept (in_valid & in_ready):
  - next_col = acc ^ in_data.
  - next_cnt = (cnt == MAX_BEATS) ? MAX_BEATS : cnt+1.
  - next_ovf = ovf_acc | (cnt == MAX_BEATS).
- FSM states:
  - IDLE: no beat held. Accepted non-last beat -> ACCUM (acc=in_data, cnt=1). Accepted last beat -> stay IDLE, load output.
  - ACCUM: accepted non-last beat -> update acc/cnt/ovf_acc. Accepted last beat -> load output, clear acc/cnt/ovf_acc, -> IDLE.
- Output load:
  - out_col=next_col, out_par=^next_col ^ ODD_PARITY, out_beats=next_cnt, out_ovf=next_ovf, out_valid=1.
  - Latency: result visible the cycle after the last beat is accepted.
  - Throughput: 1 beat/cycle while out_ready=1.
- Output hold: while out_valid & ~out_ready, all out_* are stable and in_ready=0.
- Simultaneous output consume and last-beat accept: the new result loads and out_valid stays 1, with no bubble.
- Output consumed and no new last beat: out_valid -> 0. out_* data retain their last values (don't-care).
- Flush (sync, priority below rst, above beats):
  - acc=0, cnt=0, ovf_acc=0, state -> IDLE.
  - in_ready=0, so no beat is accepted that cycle.
  - The output register is unaffected; a pending result stays valid.
- Overflow: a frame of N > MAX_BEATS beats reports out_beats=MAX_BEATS and out_ovf=1. out_col still covers all N beats.
- Width rules: all XOR is bitwise at DATA_W. cnt is unsigned CNT_W bits and never wraps.

Decomposition:
- Shared package xor_pkg:
  - clog2 function for CNT_W.
  - state typedef {IDLE, ACCUM}.
  - parity-mode constants EVEN=0, ODD=1.
- One sub-module xor_reduce: parametrised combinational XOR tree of width W producing a 1-bit reduction. Instantiated for out_par.
- FSM, accumulator, counter and output register live in xor_frame_parity.

Test Plan (DATA_W=8, MAX_BEATS=4, ODD_PARITY=0 unless stated):
- Single beat 0xA5 with last, out_ready=1 -> next cycle out_valid=1, out_col=0xA5, out_par=0, out_beats=1, out_ovf=0.
- Beats 0x0F, 0xF0, 0x01(last) on consecutive cycles -> out_col=0xFE, out_par=1, out_beats=3. Back-to-back second frame 0x3C(last) -> out_col=0x3C, out_par=0, with out_valid held high with no gap.
- Backpressure: result pending with out_ready=0 for 5 cycles -> in_ready=0, out_* unchanged. Raise out_ready with last beat 0x80 presented -> consume and reload in the same cycle, out_col=0x80, out_par=1.
- Overflow: six beats of 0x01, last on the sixth -> out_col=0x00, out_par=0, out_beats=4, out_ovf=1.
- Flush: beat 0xFF (non-last), then flush=1 for one cycle with in_valid=1 (beat not accepted), then 0x03(last) -> out_col=0x03, out_beats=1. Assert rst mid-frame after 0x55 -> outputs zero immediately, next 0x0A(last) gives out_col=0x0A, out_beats=1.
- ODD_PARITY=1: single beat 0x00(last) -> out_par=1. Single beat 0x01(last) -> out_par=0.
